gpio_uart_rx: RTL

Serial byte receiver that samples one GPIO pad input of the openframe project wrapper and turns 8N1 asynchronous frames into bytes. It is the receiving counterpart of the user-design serial outputs driven onto `gpio_out`. It sits inside the user project next to the design logic. It buffers received bytes in a small first-word-fall-through FIFO and presents them on a valid/ready handshake.

---
 rtl/gpio_uart_rx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gpio_uart_rx.sv
// 8N1 serial receiver for one openframe GPIO pad input, with a small
// first-word-fall-through byte FIFO presented on a valid/ready handshake.
module gpio_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic       rx_oeb,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] HalfLoad = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FullLoad = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_s_q;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;

    logic          timer_done;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic          empty;
    logic          full;

    assign rx_oeb = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    timer_d = HalfLoad;
                end
            end
            StStart: begin
                if (!timer_done) begin
                    timer_d = timer_q - TW'(1);
                end else if (rx_s_q) begin
                    state_d = StIdle;
                end else begin
                    state_d   = StData;
                    timer_d   = FullLoad;
                    bit_idx_d = 3'd0;
                end
            end
            StData: begin
                if (!timer_done) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    timer_d = FullLoad;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (!timer_done) begin
                    timer_d = timer_q - TW'(1);
                end else if (rx_s_q) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = StWaitIdle;
                end
            end
            StWaitIdle: begin
                // A held-low break stays here, so it raises only one frame error.
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign valid = !empty;
    assign pop   = valid && ready;

    // A pop in the same cycle frees the head slot, so a push to a full FIFO still lands.
    always_comb begin
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        wptr_d    = wptr_q + {{AW{1'b0}}, wr_en};
        rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (wr_en) begin
                mem_q[wptr_q[AW-1:0]] <= shift_q;
            end
        end
    end

    assign data      = mem_q[rptr_q[AW-1:0]];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
